// File: rtl/codec_frame_ctrl_pkg.sv
// Shared types and constants for the codec frame controller.
package codec_frame_ctrl_pkg;

  localparam int unsigned FRAME_WIDTH = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DEC  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/codec_frame_ctrl.sv
// Frame controller: serialises a frame bit-by-bit into an external coder and
// reassembles the decoder's output, aborting the frame on a decoder error.
module codec_frame_ctrl
  import codec_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = FRAME_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     bit_o,
  input  logic                     dec_bit_i,
  input  logic                     dec_err_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [$clog2(WIDTH)-1:0] err_pos_o,
  output logic [WIDTH-1:0]         data_o
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [IW-1:0]    pos_q, pos_d;
  logic             bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and next-output logic; outputs are precomputed from the next state
  // so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    data_d  = data_q;
    err_d   = err_q;
    pos_d   = pos_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          frame_d = data_i;
          idx_d   = '0;
          data_d  = '0;
          err_d   = 1'b0;
          pos_d   = '0;
          state_d = ENC;
        end
      end
      ENC: state_d = DEC;
      DEC: begin
        data_d[idx_q] = dec_bit_i;
        // A decoder error wins over the last-bit check.
        if (dec_err_i) begin
          err_d   = 1'b1;
          pos_d   = idx_q;
          state_d = DONE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ENC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    bit_d  = ((state_d == ENC) || (state_d == DEC)) ? frame_d[idx_d] : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      pos_q   <= '0;
      bit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bit_o     = bit_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign err_pos_o = pos_q;
  assign data_o    = data_q;

endmodule

// File: tb/tb_codec_frame_ctrl.sv
// Scoreboard bench for codec_frame_ctrl with a loop-back coder/decoder model.
module tb_codec_frame_ctrl;

  localparam int unsigned W  = 23;
  localparam int unsigned IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  data_in;
  logic          bit_out;
  logic          dec_bit;
  logic          dec_err;
  logic          busy;
  logic          done;
  logic          err;
  logic [IW-1:0] err_pos;
  logic [W-1:0]  data_out;

  codec_frame_ctrl #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .data_i    (data_in),
    .bit_o     (bit_out),
    .dec_bit_i (dec_bit),
    .dec_err_i (dec_err),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .err_pos_o (err_pos),
    .data_o    (data_out)
  );

  always #5 clk = ~clk;

  // Ideal coder/decoder pair: the decoded bit is the transmitted bit.
  assign dec_bit = bit_out;

  typedef struct {
    logic [W-1:0]  data;
    logic          err;
    logic [IW-1:0] pos;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  int           obs_lat;
  logic [W-1:0] obs_bits;
  int           obs_busy_bad;

  function automatic exp_t model(input logic [W-1:0] d, input int err_bit);
    exp_t e;
    e.data = d;
    e.err  = 1'b0;
    e.pos  = '0;
    e.lat  = 2 * W + 1;
    if (err_bit >= 0) begin
      for (int i = 0; i < W; i++) if (i > err_bit) e.data[i] = 1'b0;
      e.err = 1'b1;
      e.pos = IW'(err_bit);
      e.lat = 2 * err_bit + 3;
    end
    return e;
  endfunction

  // Runs one frame: pushes the expected result, records latency, ENC-cycle bits and busy.
  task automatic drive_frame(input logic [W-1:0] d, input int err_bit, input bit err_outside);
    sb.push_back(model(d, err_bit));
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    dec_err = err_outside;
    obs_lat = -1;
    obs_bits = '0;
    obs_busy_bad = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if ((c % 2 == 1) && ((c - 1) / 2 < W)) obs_bits[(c - 1) / 2] = bit_out;
      if (busy !== 1'b1) obs_busy_bad++;
      start   = 1'b0;
      dec_err = err_outside ? (c % 2 == 1) : (c == 2 * err_bit + 2);
      if (done === 1'b1) begin
        obs_lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; data_in = '1; dec_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, bit_out, done, err, err_pos, data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b bit=%b done=%b err=%b pos=%0d data=%h, required all zero",
               busy, bit_out, done, err, err_pos, data_out);
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_loopback();
    logic [W-1:0] vals[4];
    exp_t e;
    vals[0] = 23'd8201481;
    for (int i = 1; i < 4; i++) vals[i] = W'($urandom());
    for (int i = 0; i < 4; i++) begin
      drive_frame(vals[i], -1, 1'b0);
      e = sb.pop_front();
      n_tests++;
      if (obs_lat !== e.lat || data_out !== e.data || err !== e.err || err_pos !== e.pos) begin
        n_fail++;
        $display("FAIL loopback_%0d: lat=%0d data=%h err=%b pos=%0d, required lat=%0d data=%h err=%b pos=%0d",
                 i, obs_lat, data_out, err, err_pos, e.lat, e.data, e.err, e.pos);
      end
      n_tests++;
      if (obs_bits !== e.data || obs_busy_bad != 0) begin
        n_fail++;
        $display("FAIL loopback_bits_%0d: bits=%h busy_low=%0d, required bits=%h busy_low=0",
                 i, obs_bits, obs_busy_bad, e.data);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || data_out !== e.data) begin
        n_fail++;
        $display("FAIL done_pulse_%0d: done=%b busy=%b data=%h, required done=0 busy=0 data=%h",
                 i, done, busy, data_out, e.data);
      end
    end
  endtask

  task automatic test_error();
    int bits[3];
    logic [W-1:0] vals[3];
    exp_t e;
    bits[0] = 5;  vals[0] = 23'h7FFFFF;
    bits[1] = 0;  vals[1] = W'($urandom());
    bits[2] = W - 1; vals[2] = W'($urandom());
    for (int i = 0; i < 3; i++) begin
      drive_frame(vals[i], bits[i], 1'b0);
      e = sb.pop_front();
      n_tests++;
      if (obs_lat !== e.lat || data_out !== e.data || err !== e.err || err_pos !== e.pos) begin
        n_fail++;
        $display("FAIL error_bit%0d: lat=%0d data=%h err=%b pos=%0d, required lat=%0d data=%h err=%b pos=%0d",
                 bits[i], obs_lat, data_out, err, err_pos, e.lat, e.data, e.err, e.pos);
      end
      n_tests++;
      if (obs_bits !== e.data || obs_busy_bad != 0) begin
        n_fail++;
        $display("FAIL error_bits_%0d: bits=%h busy_low=%0d, required bits=%h busy_low=0",
                 bits[i], obs_bits, obs_busy_bad, e.data);
      end
    end
    dec_err = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (err !== 1'b1 || err_pos !== e.pos || data_out !== e.data || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL error_hold: err=%b pos=%0d data=%h busy=%b, required err=1 pos=%0d data=%h busy=0",
               err, err_pos, data_out, busy, e.pos, e.data);
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] d1, d2;
    exp_t e;
    int ndone;
    d1 = W'($urandom());
    d2 = ~d1;
    sb.push_back(model(d1, -1));
    sb.push_back(model(d2, -1));
    ndone = 0;
    @(negedge clk);
    start = 1'b1; data_in = d1; dec_err = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) data_in = d2;
      if (done === 1'b1) begin
        e = sb.pop_front();
        ndone++;
        n_tests++;
        if (c != e.lat + (ndone - 1) * (2 * W + 2) || data_out !== e.data || err !== 1'b0) begin
          n_fail++;
          $display("FAIL start_held_%0d: done_cycle=%0d data=%h err=%b, required done_cycle=%0d data=%h err=0",
                   ndone, c, data_out, err, e.lat + (ndone - 1) * (2 * W + 2), e.data);
        end
        if (ndone == 2) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (ndone != 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_held_count: frames=%0d busy=%b, required frames=2 busy=0", ndone, busy);
    end
    while (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d2;
    exp_t e;
    int done_at;
    d2 = W'($urandom());
    done_at = -1;
    @(negedge clk);
    start = 1'b1; data_in = W'($urandom()); dec_err = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 22) rst = 1'b1;
      if (c == 23) begin
        n_tests++;
        if (busy !== 1'b0 || bit_out !== 1'b0 || data_out !== '0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid: busy=%b bit=%b data=%h done=%b, required all zero",
                   busy, bit_out, data_out, done);
        end
        rst = 1'b0; start = 1'b1; data_in = d2;
        sb.push_back(model(d2, -1));
      end
      if (c > 23 && done === 1'b1) begin
        done_at = c;
        break;
      end
    end
    e = sb.pop_front();
    n_tests++;
    if (done_at != 23 + e.lat || data_out !== e.data || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart: done_cycle=%0d data=%h err=%b, required done_cycle=%0d data=%h err=0",
               done_at, data_out, err, 23 + e.lat, e.data);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals[2];
    exp_t e;
    vals[0] = '0;
    vals[1] = 23'h555555;
    for (int i = 0; i < 2; i++) begin
      drive_frame(vals[i], -1, 1'b0);
      e = sb.pop_front();
      n_tests++;
      if (obs_lat !== e.lat || data_out !== e.data || err !== 1'b0 || obs_busy_bad != 0) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: lat=%0d data=%h err=%b busy_low=%0d, required lat=%0d data=%h err=0 busy_low=0",
                 i, obs_lat, data_out, err, obs_busy_bad, e.lat, e.data);
      end
    end
  endtask

  task automatic test_err_outside_dec();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive_frame(W'($urandom()), -1, 1'b1);
      e = sb.pop_front();
      n_tests++;
      if (obs_lat !== e.lat || data_out !== e.data || err !== 1'b0) begin
        n_fail++;
        $display("FAIL err_outside_dec_%0d: lat=%0d data=%h err=%b, required lat=%0d data=%h err=0",
                 i, obs_lat, data_out, err, e.lat, e.data);
      end
    end
    dec_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; dec_err = 1'b0;
    test_reset();
    test_loopback();
    test_error();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    test_err_outside_dec();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/codec_frame_ctrl.md
CODEC_FRAME_CTRL -- requirements
Module: codec_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 23, number of bits per frame (2..32).
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1 bit, frame request, sampled only in IDLE.
REQ-005 SHALL have port data_i, input, WIDTH bits, frame to transmit, LSB sent first.
REQ-006 SHALL have port bit_o, output, 1 bit, drives Coder bit_i.
REQ-007 SHALL have port dec_bit_i, input, 1 bit, from Decoder bit_o.
REQ-008 SHALL have port dec_err_i, input, 1 bit, from Decoder error_flag.
REQ-009 SHALL have port busy_o, output, 1 bit, high in every state except IDLE.
REQ-010 SHALL have port done_o, output, 1 bit, one-cycle frame-complete pulse.
REQ-011 SHALL have port err_o, output, 1 bit, frame aborted by decoder error; valid while done_o=1 and held until next accepted start.
REQ-012 SHALL have port err_pos_o, output, $clog2(WIDTH) bits, index of the failing bit; valid with err_o.
REQ-013 SHALL have port data_o, output, WIDTH bits, decoded frame; valid from done_o until next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, ENC, DEC, DONE.
REQ-015 IDLE: on start_i=1, SHALL latch data_i, clear idx, data_o, err_o and err_pos_o, then enter ENC.
REQ-016 IDLE: start_i=0 SHALL leave the FSM in IDLE; start_i SHALL be ignored in all other states (no queueing).
REQ-017 ENC: bit_o SHALL equal latched data[idx]; the next state SHALL be DEC unconditionally.
REQ-018 DEC: bit_o SHALL hold data[idx]; at the end of the cycle the block SHALL write dec_bit_i into data_o[idx] and sample dec_err_i.
REQ-019 DEC with dec_err_i=1 SHALL set err_o=1 and err_pos_o=idx, then enter DONE. Error takes priority over the last-bit check.
REQ-020 DEC with no error and idx=WIDTH-1 SHALL enter DONE; otherwise it SHALL increment idx and return to ENC.
REQ-021 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-022 dec_bit_i and dec_err_i SHALL be ignored outside DEC.
REQ-023 bit_o SHALL be 0 in IDLE and DONE.
REQ-024 Latency, error-free: done_o SHALL assert exactly 2*WIDTH+1 cycles after the cycle where start_i is accepted (47 for WIDTH=23).
REQ-025 Back-to-back: the earliest next accepted start SHALL be the cycle after DONE, giving a frame period of 2*WIDTH+2 cycles.
REQ-026 idx SHALL be an unsigned counter of $clog2(WIDTH) bits and SHALL never exceed WIDTH-1 (no wrap-around).
REQ-027 On an aborted frame, data_o bits above err_pos_o SHALL read 0; bit err_pos_o SHALL hold the sampled dec_bit_i.

Reset
REQ-028 rst_i=1 at any clock edge SHALL force IDLE, bit_o=0, busy_o=0, done_o=0, err_o=0, err_pos_o=0, data_o=0 and idx=0, including mid-frame. Reset SHALL take priority over start_i.
REQ-029 After reset release, the first cycle SHALL be able to accept start_i.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, ENC, DEC, DONE) and the default frame width constant (23).
REQ-031 SHALL be a single module with no sub-modules; Coder and Decoder are instantiated alongside it by the integrating level, not inside it.

Verification
REQ-032 data_i=23'd8201481 with a loop-back Coder/Decoder and start pulse -> done_o after 47 cycles, data_o=8201481, err_o=0.
REQ-033 data_i=23'h7FFFFF, decoder model forcing dec_err_i=1 in the DEC cycle of bit 5 -> done_o after 13 cycles, err_o=1, err_pos_o=5, data_o[22:6]=0.
REQ-034 start_i held high through the whole frame -> exactly one frame is run; the next frame starts on the cycle after done_o and its done_o follows 48 cycles after the first.
REQ-035 rst_i pulsed in the DEC cycle of bit 10 -> next cycle busy_o=0, bit_o=0, data_o=0, and no done_o pulse appears.
REQ-036 data_i=0 followed by a frame with data_i=23'h555555 -> data_o=0 and then data_o=0x555555, err_o=0 on both.
REQ-037 dec_err_i=1 held only during ENC, IDLE and DONE cycles -> err_o stays 0 and data_o is correct.
